// File: rtl/wb_pipe_stage.sv
// Elastic writeback pipeline register: STAGES two-entry skid-buffer slices in series with flush and occupancy.
// Optional WB_PIPE_PERF_EN adds a saturating stall_cycles counter output.
module wb_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int STAGES = 1,
  localparam int OCC_W = $clog2(2*STAGES+1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy
`ifdef WB_PIPE_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  // Link k is the input of slice k; link STAGES is the block output.
  logic [STAGES:0]   link_valid;
  logic [STAGES:0]   link_ready;
  logic [DATA_W-1:0] link_data [STAGES+1];
  logic [CTRL_W-1:0] link_ctrl [STAGES+1];

  assign link_valid[0]      = in_valid;
  assign link_data[0]       = in_data;
  assign link_ctrl[0]       = in_ctrl;
  assign link_ready[STAGES] = out_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_acc;

    // Ready comes straight from the skid flop, so no out_ready path reaches upstream.
    assign link_ready[gi]     = !skid_valid_q;
    assign link_valid[gi+1]   = main_valid_q;
    assign link_data[gi+1]    = main_data_q;
    assign link_ctrl[gi+1]    = main_ctrl_q;

    always_comb begin
      main_valid_d = main_valid_q;
      main_data_d  = main_data_q;
      main_ctrl_d  = main_ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;
      in_acc       = link_valid[gi] && !skid_valid_q;
      if (flush) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else if (!main_valid_q || link_ready[gi+1]) begin
        if (skid_valid_q) begin
          main_valid_d = 1'b1;
          main_data_d  = skid_data_q;
          main_ctrl_d  = skid_ctrl_q;
          skid_valid_d = 1'b0;
        end else begin
          main_valid_d = in_acc;
          if (in_acc) begin
            main_data_d = link_data[gi];
            main_ctrl_d = link_ctrl[gi];
          end
        end
      end else if (in_acc) begin
        skid_valid_d = 1'b1;
        skid_data_d  = link_data[gi];
        skid_ctrl_d  = link_ctrl[gi];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        main_valid_q <= 1'b0;
        skid_valid_q <= 1'b0;
        main_data_q  <= '0;
        skid_data_q  <= '0;
        main_ctrl_q  <= '0;
        skid_ctrl_q  <= '0;
      end else begin
        main_valid_q <= main_valid_d;
        skid_valid_q <= skid_valid_d;
        main_data_q  <= main_data_d;
        skid_data_q  <= skid_data_d;
        main_ctrl_q  <= main_ctrl_d;
        skid_ctrl_q  <= skid_ctrl_d;
      end
    end
  end

  assign in_ready  = link_ready[0];
  assign out_valid = link_valid[STAGES];
  assign out_data  = link_data[STAGES];
  assign out_ctrl  = out_valid ? link_ctrl[STAGES] : '0;

  logic             in_fire, out_fire;
  logic [OCC_W-1:0] occ_q, occ_d;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    occ_d = occ_q + OCC_W'(in_fire) - OCC_W'(out_fire);
    if (flush) begin
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

`ifdef WB_PIPE_PERF_EN
  logic [31:0] stall_q, stall_d;

  // Flush does not touch the counter; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Scoreboard bench for wb_pipe_stage (STAGES=2); stall counter checked when WB_PIPE_PERF_EN is defined.
module tb_wb_pipe_stage;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 8;
  localparam int STAGES = 2;
  localparam int OCC_W  = $clog2(2*STAGES+1);

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [OCC_W-1:0]  occupancy;
`ifdef WB_PIPE_PERF_EN
  logic [31:0]       stall_cycles;
`endif

  wb_pipe_stage #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
`ifdef WB_PIPE_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    int                cyc;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   idx;
  bit   chk_lat = 1'b0;
  bit   last_in_fire;
  bit   last_out_valid;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: drive after negedge, check outputs, cross the edge, update the model.
  task automatic step(input logic iv, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                      input logic ordy, input logic fl);
    bit ifire, ofire;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    #1;
    check("occupancy", 64'(occupancy), 64'(sb.size()));
    last_out_valid = out_valid;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(1), 64'(0));
      end else begin
        check("out_data", 64'(out_data), 64'(sb[0].d));
        check("out_ctrl", 64'(out_ctrl), 64'(sb[0].c));
      end
    end else begin
      check("idle_ctrl", 64'(out_ctrl), 64'(0));
    end
    ifire = iv && in_ready;
    ofire = out_valid && ordy;
    last_in_fire = ifire;
    @(posedge clk);
    if (ofire && sb.size() > 0) begin
      $display("out cyc=%0d data=%h ctrl=%h", cyc, sb[0].d, sb[0].c);
      if (chk_lat) check("latency", 64'(cyc - sb[0].cyc), 64'(STAGES));
      void'(sb.pop_front());
    end
    if (fl) sb.delete();
    else if (ifire) sb.push_back('{d, c, cyc});
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_occupancy", 64'(occupancy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back stream with out_ready high.
    chk_lat = 1'b1;
    step(1'b1, 32'hA, 8'h81, 1'b1, 1'b0);
    step(1'b1, 32'hB, 8'h82, 1'b1, 1'b0);
    for (int n = 0; n < STAGES + 1; n++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("stream_drained", 64'(sb.size()), 64'(0));
    chk_lat = 1'b0;

    // Fill while stalled: only 2*STAGES entries fit.
    idx = 1;
    for (int n = 0; n < 4*STAGES + 4 && idx <= 2*STAGES + 1; n++) begin
      step(1'b1, DATA_W'(idx), CTRL_W'(8'h40 + idx), 1'b0, 1'b0);
      if (last_in_fire) idx++;
    end
    check("full_occupancy", 64'(occupancy), 64'(2*STAGES));
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_accepted", 64'(idx), 64'(2*STAGES + 1));
    for (int n = 0; n < 2*STAGES + 1; n++) begin
      step(idx <= 2*STAGES + 1, DATA_W'(idx), CTRL_W'(8'h40 + idx), 1'b1, 1'b0);
      check("drain_no_gap", 64'(last_out_valid), 64'(1));
      if (last_in_fire) idx++;
    end
    check("drain_all_accepted", 64'(idx), 64'(2*STAGES + 2));
    step(1'b0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(sb.size()), 64'(0));

    // Flush with three entries in flight and an input offered.
    for (int n = 0; n < 3; n++) step(1'b1, DATA_W'(32'h100 + n), CTRL_W'(n + 1), 1'b0, 1'b0);
    check("preflush_occ", 64'(occupancy), 64'(3));
    step(1'b1, 32'hDEAD, 8'h55, 1'b0, 1'b1);
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check("flush_out_ctrl", 64'(out_ctrl), 64'(0));
    check("flush_occ", 64'(occupancy), 64'(0));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    for (int n = 0; n < 2*STAGES + 2; n++) step(1'b0, '0, '0, 1'b1, 1'b0);

    // Asynchronous reset mid-stall.
    for (int n = 0; n < 2; n++) step(1'b1, DATA_W'(32'h200 + n), 8'h22, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("arst_occ", 64'(occupancy), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    chk_lat = 1'b1;
    step(1'b1, 32'h77, 8'h11, 1'b1, 1'b0);
    for (int n = 0; n < STAGES + 1; n++) step(1'b0, '0, '0, 1'b1, 1'b0);
    check("post_rst_drained", 64'(sb.size()), 64'(0));
    chk_lat = 1'b0;

    // Random valid/ready traffic with rare flushes.
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), CTRL_W'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
    end

`ifdef WB_PIPE_PERF_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    step(1'b1, 32'h5, 8'h5, 1'b0, 1'b0);
    for (int n = 0; n < STAGES - 1; n++) step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int n = 0; n < 7; n++) step(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_before_flush", 64'(stall_cycles), 64'(7));
    step(1'b0, '0, '0, 1'b1, 1'b1);
    check("stall_after_flush", 64'(stall_cycles), 64'(7));
    step(1'b0, '0, '0, 1'b0, 1'b0);
    check("stall_idle", 64'(stall_cycles), 64'(7));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
